// File: rtl/i2f_conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : i2f_conv_sched
// Brief    : Round-robin shared 8-bit signed int to 13-bit float converter.
//            Define I2F_FAST_NORM_EN for single-cycle normalization.
// Revision : 1.0 - initial release
// ============================================================================
module i2f_conv_sched #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output logic [12:0]          out_float,
  output logic [ID_W-1:0]      out_id,
  input  logic                 out_ready
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_norm = 2'd1;
  localparam logic [1:0] c_st_out  = 2'd2;

  logic [1:0]      r_state;
  logic [ID_W-1:0] r_ptr;
  logic            r_sign;
  logic [3:0]      r_exp;
  logic [7:0]      r_frac;
  logic [ID_W-1:0] r_id;

  logic            w_found;
  logic [ID_W-1:0] w_idx;
  logic [7:0]      w_sel;
  logic [7:0]      w_mag;

  // First pending requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin : arb
    int j;
    w_found = 1'b0;
    w_idx   = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[j]) begin
        w_found = 1'b1;
        w_idx   = ID_W'(j);
      end
    end
  end

  assign w_sel = req_data[{w_idx, 3'b000} +: 8];
  assign w_mag = w_sel[7] ? (~w_sel + 8'd1) : w_sel;

  always_comb begin
    req_ready = '0;
    if (reset_n && (r_state == c_st_idle) && w_found) begin
      req_ready[w_idx] = 1'b1;
    end
  end

`ifdef I2F_FAST_NORM_EN
  logic [2:0] w_lz;
  logic [7:0] w_norm_frac;
  logic [3:0] w_norm_exp;

  always_comb begin
    w_lz = '0;
    for (int b = 0; b < 8; b++) begin
      if (r_frac[b]) w_lz = 3'(7 - b);
    end
  end

  assign w_norm_frac = r_frac << w_lz;
  assign w_norm_exp  = r_exp - {1'b0, w_lz};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_st_idle;
      r_ptr     <= '0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_frac    <= '0;
      r_id      <= '0;
      out_valid <= 1'b0;
      out_float <= '0;
      out_id    <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_found) begin
            r_sign <= (w_mag == 8'd0) ? 1'b0 : w_sel[7];
            r_exp  <= 4'd8;
            r_frac <= w_mag;
            r_id   <= w_idx;
            r_ptr  <= (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + ID_W'(1);
            if (w_mag == 8'd0) begin
              // Zero skips normalization and presents an all-zero float.
              r_state   <= c_st_out;
              out_valid <= 1'b1;
              out_float <= '0;
              out_id    <= w_idx;
            end else begin
              r_state <= c_st_norm;
            end
          end
        end
        c_st_norm: begin
`ifdef I2F_FAST_NORM_EN
          r_frac    <= w_norm_frac;
          r_exp     <= w_norm_exp;
          r_state   <= c_st_out;
          out_valid <= 1'b1;
          out_float <= {r_sign, w_norm_exp, w_norm_frac};
          out_id    <= r_id;
`else
          if (r_frac[7]) begin
            r_state   <= c_st_out;
            out_valid <= 1'b1;
            out_float <= {r_sign, r_exp, r_frac};
            out_id    <= r_id;
          end else begin
            r_frac <= r_frac << 1;
            r_exp  <= r_exp - 4'd1;
          end
`endif
        end
        c_st_out: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2f_conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2f_conv_sched
// Brief    : Scoreboard bench for i2f_conv_sched (honours I2F_FAST_NORM_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2f_conv_sched;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [8*NREQ-1:0]    req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic [12:0]          out_float;
  logic [ID_W-1:0]      out_id;
  logic                 out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [14:0] sb_q[$];   // {id, float}

  i2f_conv_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_float (out_float),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference: value = 0.frac * 2^e with 2^(e-1) <= |d| < 2^e.
  function automatic logic [12:0] model(input logic [7:0] d);
    logic [7:0] m;
    int e;
    m = d[7] ? 8'(-d) : d;
    if (m == 8'd0) return 13'h0000;
    e = 0;
    for (int k = 1; k <= 8; k++) begin
      if (9'(m) >= (9'd1 << (k - 1))) e = k;
    end
    return {d[7], 4'(e), 8'(m << (8 - e))};
  endfunction

  function automatic int exp_lat(input logic [7:0] d);
    logic [12:0] f;
    f = model(d);
    if (f == 13'h0000) return 1;
`ifdef I2F_FAST_NORM_EN
    return 2;
`else
    return 2 + 8 - int'(f[11:8]);
`endif
  endfunction

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got id=%0d float=%h required none", out_id, out_float);
      end else begin
        logic [14:0] exp_v;
        exp_v = sb_q.pop_front();
        if ({out_id, out_float} !== exp_v) begin
          errors++;
          $display("FAIL result got id=%0d float=%b required id=%0d float=%b",
                   out_id, out_float, exp_v[14:13], exp_v[12:0]);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '1;
    req_data  = 32'h19E7_8001;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    if (out_float !== 13'h0) begin errors++; $display("FAIL reset_out_float got %h required 0", out_float); end
    if (out_id !== '0) begin errors++; $display("FAIL reset_out_id got %0d required 0", out_id); end
    if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b required 0", req_ready); end
    @(posedge clk); #2;
    req_valid = '0;
    reset_n   = 1'b1;
  endtask

  task automatic test_single(input int id, input logic [7:0] d, input logic [12:0] expf);
    int lat;
    bit seen;
    @(posedge clk); #2;
    req_data[8*id +: 8] = d;
    req_valid = NREQ'(1 << id);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== NREQ'(1 << id)) begin
      errors++;
      $display("FAIL grant_single got %b required %b", req_ready, NREQ'(1 << id));
    end
    sb_q.push_back({ID_W'(id), expf});
    @(posedge clk); #2;
    req_valid = '0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || lat != exp_lat(d)) begin
      errors++;
      $display("FAIL latency data=%h got %0d required %0d", d, lat, exp_lat(d));
    end
    drain();
  endtask

  task automatic test_sweep();
    logic [7:0] vals [10] = '{8'd2, 8'd3, 8'd64, 8'hFF, 8'hC0, 8'h81, 8'd100, 8'h9C, 8'd63, 8'h7F};
    for (int k = 0; k < 10; k++) begin
      test_single(k % NREQ, vals[k], model(vals[k]));
    end
  endtask

  task automatic test_round_robin();
    int n;
    @(posedge clk); #2;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n   = 1'b1;
    req_data  = {8'd15, 8'd5, 8'hFB, 8'hF1};
    req_valid = '1;
    out_ready = 1'b1;
    for (int g = 0; g < 8; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (req_ready == '0 && n < 20);
      checks++;
      if (req_ready !== NREQ'(1 << (g % NREQ))) begin
        errors++;
        $display("FAIL rr_order grant#%0d got %b required %b", g, req_ready, NREQ'(1 << (g % NREQ)));
      end
      sb_q.push_back({ID_W'(g % NREQ), model(req_data[8*(g % NREQ) +: 8])});
      @(posedge clk);
    end
    #2;
    req_valid = '0;
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    logic [12:0] hold_f;
    logic [ID_W-1:0] hold_id;
    @(posedge clk); #2;
    out_ready = 1'b0;
    req_data  = {8'd77, 8'd100, 8'hFD, 8'd9};
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got %b required 0100", req_ready); end
    sb_q.push_back({2'd2, model(8'd100)});
    @(posedge clk); #2;
    req_valid = 4'b1011;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    hold_f  = out_float;
    hold_id = out_id;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_float !== hold_f || out_id !== hold_id || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b f=%h id=%0d rdy=%b required v=1 f=%h id=%0d rdy=0",
                 c, out_valid, out_float, out_id, req_ready, hold_f, hold_id);
      end
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b required 0", out_valid); end
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant got %b required 1000", req_ready); end
    sb_q.push_back({2'd3, model(8'd77)});
    @(posedge clk); #2;
    req_valid = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #2;
    req_data  = {8'd40, 8'd30, 8'd1, 8'hEC};
    req_valid = 4'b0010;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant got %b required 0010", req_ready); end
    @(posedge clk); #2;
    reset_n   = 1'b0;
    req_valid = '1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_float !== 13'h0 || out_id !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got v=%b f=%h id=%0d rdy=%b required all 0",
               out_valid, out_float, out_id, req_ready);
    end
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_priority got %b required 0001", req_ready); end
    sb_q.push_back({2'd0, model(8'hEC)});
    @(posedge clk); #2;
    req_valid = '0;
    drain();
    repeat (12) @(negedge clk);
    checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle got pending=%0d v=%b required 0 0", sb_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single(0, 8'd25,  13'b0_0101_1100_1000);
    test_single(1, 8'h80,  13'b1_1000_1000_0000);
    test_single(1, 8'hE7,  13'b1_0101_1100_1000);
    test_single(2, 8'd0,   13'h0000);
    test_single(3, 8'd127, 13'b0_0111_1111_1110);
    test_single(0, 8'd1,   13'b0_0001_1000_0000);
    test_sweep();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
